matrix_op_sequencer: RTL and testbench
======================================

// Module: matrix_op_sequencer
// PURPOSE
//  Sequences one matrix operation against matrix_storage and the compute engine. Accepts a command
//  (opcode, A id, B id) and drives load_operands. Checks operand dimensions, starts the engine and
//  latches its result, then pulses op_done and streams the result elements to storage for write-back.
//  Sits between the UI/command FSM and the storage/engine pair; only one operation is in flight at a time.
// PARAMETERS
//  DATA_W   8    element width
//  NELEM    25   max elements per matrix (5x5)
//  TIMEOUT  255  engine-wait limit in cycles (used only with OP_TIMEOUT_EN)
// PORTS
//  clk            in   1            clock, rising edge
//  rst            in   1            synchronous reset, active-high
//  cmd_valid      in   1            command request
//  cmd_ready      out  1            high only in IDLE; command accepted when cmd_valid&&cmd_ready
//  cmd_op         in   3            0 add, 1 sub, 2 mul, 3 transpose, 4 scalar-mul; 5-7 illegal
//  cmd_a_id       in   4            operand A slot
//  cmd_b_id       in   4            operand B slot (ignored for ops 3,4)
//  load_operands  out  1            one-cycle pulse to storage
//  operand_a_id   out  4            latched A id
//  operand_b_id   out  4            latched B id
//  a_m,a_n,b_m,b_n in  3 each       operand dims returned by storage
//  eng_start      out  1            one-cycle engine start pulse
//  eng_op         out  3            latched opcode
//  eng_done       in   1            engine completion pulse
//  eng_res_m/n    in   3 each       result dims, valid with eng_done
//  eng_res_flat   in   DATA_W*NELEM result elements, element k at [k*DATA_W +: DATA_W], valid with eng_done
//  op_done        out  1            one-cycle pulse: result ready for storage
//  result_m/n     out  3 each       latched result dims
//  store_start    in   1            storage begins consuming; element 0 presented the same cycle
//  result_data    out  DATA_W       element at store index
//  busy           out  1            high in any state except IDLE
//  err_valid      out  1            one-cycle pulse on an aborted command
//  err_code       out  2            1 illegal op/id, 2 dimension mismatch, 3 timeout; holds until next accept
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0 except cmd_ready=1. Latched ids/dims/result buffer cleared.
//  Reset mid-operation aborts immediately; no op_done or err_valid is emitted.
//  States and transitions:
//  - IDLE: on accept, latch op/ids, clear err_code -> LOAD. An id>9 or op>4 -> ERR instead.
//  - LOAD: load_operands=1 for exactly one cycle -> SETTLE.
//  - SETTLE: one cycle for the storage dims to update -> CHECK.
//  - CHECK, ops 0/1: require a_m==b_m && a_n==b_n.
//  - CHECK, op 2: require a_n==b_m.
//  - CHECK, ops 3/4: always pass.
//  - CHECK: pass -> START; fail -> ERR (code 2).
//  - START: eng_start=1 for one cycle -> WAIT.
//  - WAIT: on eng_done, latch eng_res_flat/m/n -> DONE. An eng_done outside WAIT is ignored.
//  - DONE: op_done=1 for one cycle -> STORE.
//  - STORE: idx=0. The cycle store_start is seen, result_data=elem[0]; idx increments each following
//    cycle. After elem[result_m*result_n-1] is presented -> IDLE.
//  - ERR: err_valid=1 for one cycle -> IDLE.
//  Latency: accept at cycle 0; load_operands at 1; CHECK at 3; eng_start at 4.
//  result_data is combinational from the latched buffer and idx; elements beyond m*n read as 0.
//  result_m*result_n is computed 3x3 -> 6 bits; a result dim of 0 gives 0 elements: STORE exits the
//  cycle after store_start.
//  A cmd_valid while busy is not accepted; the command must be held until cmd_ready.
// CONFIGURATION
//  OP_TIMEOUT_EN defined: WAIT counts cycles from entry. After TIMEOUT cycles without eng_done ->
//    ERR (code 3), with no op_done. An eng_done on the same cycle the counter expires wins (normal path).
//  OP_TIMEOUT_EN undefined: WAIT waits indefinitely; code 3 is never produced.
// TESTING
//  1 add 2x3 A=id0,B=id1 -> load_operands@1, eng_start@4; eng_done -> op_done; store_start ->
//    6 elements in order, then cmd_ready=1.
//  2 mul with A 2x3, B 2x2 -> err_valid pulse, err_code=2; no eng_start.
//  3 cmd_op=6 or cmd_a_id=12 -> err_valid the cycle after accept, err_code=1; no load_operands.
//  4 transpose A 3x5, engine returns 5x3 -> result_m=5, result_n=3; 15 elements; elem[15..24] never output.
//  5 OP_TIMEOUT_EN, TIMEOUT=8, no eng_done -> err_code=3 after 8 WAIT cycles; a later eng_done is ignored.
//  6 rst asserted in WAIT and in STORE -> next cycle state IDLE, all outputs at reset values,
//    no op_done/err_valid.

Source files
------------

// File: rtl/matrix_op_sequencer_if.sv
// Bundle of command, storage, engine and write-back signals around matrix_op_sequencer.
// master: the sequencer itself; slave: the command source, storage and engine side.
interface matrix_op_sequencer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NELEM  = 25
);
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [2:0]                cmd_op;
  logic [3:0]                cmd_a_id;
  logic [3:0]                cmd_b_id;
  logic                      load_operands;
  logic [3:0]                operand_a_id;
  logic [3:0]                operand_b_id;
  logic [2:0]                a_m;
  logic [2:0]                a_n;
  logic [2:0]                b_m;
  logic [2:0]                b_n;
  logic                      eng_start;
  logic [2:0]                eng_op;
  logic                      eng_done;
  logic [2:0]                eng_res_m;
  logic [2:0]                eng_res_n;
  logic [DATA_W*NELEM-1:0]   eng_res_flat;
  logic                      op_done;
  logic [2:0]                result_m;
  logic [2:0]                result_n;
  logic                      store_start;
  logic [DATA_W-1:0]         result_data;
  logic                      busy;
  logic                      err_valid;
  logic [1:0]                err_code;

  modport master (
    input  cmd_valid, cmd_op, cmd_a_id, cmd_b_id,
    input  a_m, a_n, b_m, b_n,
    input  eng_done, eng_res_m, eng_res_n, eng_res_flat,
    input  store_start,
    output cmd_ready, load_operands, operand_a_id, operand_b_id,
    output eng_start, eng_op, op_done, result_m, result_n,
    output result_data, busy, err_valid, err_code
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a_id, cmd_b_id,
    output a_m, a_n, b_m, b_n,
    output eng_done, eng_res_m, eng_res_n, eng_res_flat,
    output store_start,
    input  cmd_ready, load_operands, operand_a_id, operand_b_id,
    input  eng_start, eng_op, op_done, result_m, result_n,
    input  result_data, busy, err_valid, err_code
  );
endinterface

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer: runs one matrix operation at a time -- operand load, dimension
// check, engine start/wait, result latch, op_done pulse and element write-back stream.
// Optional feature: define OP_TIMEOUT_EN to abort an engine wait after TIMEOUT cycles
// (err_code 3); without it the engine wait is unbounded.
module matrix_op_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NELEM   = 25,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  matrix_op_sequencer_if.master bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_LOAD   = 4'd1;
  localparam logic [3:0] S_SETTLE = 4'd2;
  localparam logic [3:0] S_CHECK  = 4'd3;
  localparam logic [3:0] S_START  = 4'd4;
  localparam logic [3:0] S_WAIT   = 4'd5;
  localparam logic [3:0] S_DONE   = 4'd6;
  localparam logic [3:0] S_STORE  = 4'd7;
  localparam logic [3:0] S_ERR    = 4'd8;

  logic [3:0]              state_q,    state_d;
  logic [2:0]              op_q,       op_d;
  logic [3:0]              a_id_q,     a_id_d;
  logic [3:0]              b_id_q,     b_id_d;
  logic [2:0]              res_m_q,    res_m_d;
  logic [2:0]              res_n_q,    res_n_d;
  logic [DATA_W*NELEM-1:0] res_flat_q, res_flat_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [5:0]              idx_q,      idx_d;
  logic                    started_q,  started_d;

  logic                    cmd_illegal;
  logic                    dims_ok;
  logic [5:0]              elem_cnt;
  logic [DATA_W-1:0]       result_data;

`ifdef OP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]           wcnt_q, wcnt_d;
`else
  // TIMEOUT only has meaning when the engine-wait limit is built in
  logic                    unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  // B slot is only meaningful for the two-operand ops (0..2)
  assign cmd_illegal = (bus.cmd_op > 3'd4) || (bus.cmd_a_id > 4'd9) ||
                       ((bus.cmd_op < 3'd3) && (bus.cmd_b_id > 4'd9));

  // Operand shape rule for the latched opcode
  always_comb begin
    dims_ok = 1'b1;
    case (op_q)
      3'd0, 3'd1: dims_ok = (bus.a_m == bus.b_m) && (bus.a_n == bus.b_n);
      3'd2:       dims_ok = (bus.a_n == bus.b_m);
      default:    dims_ok = 1'b1;
    endcase
  end

  assign elem_cnt = {3'd0, res_m_q} * {3'd0, res_n_q};

  // Next-state and latch-enable logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_id_d     = a_id_q;
    b_id_d     = b_id_q;
    res_m_d    = res_m_q;
    res_n_d    = res_n_q;
    res_flat_d = res_flat_q;
    err_code_d = err_code_q;
    idx_d      = idx_q;
    started_d  = started_q;
`ifdef OP_TIMEOUT_EN
    wcnt_d     = wcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d       = bus.cmd_op;
          a_id_d     = bus.cmd_a_id;
          b_id_d     = bus.cmd_b_id;
          err_code_d = 2'd0;
          if (cmd_illegal) begin
            err_code_d = 2'd1;
            state_d    = S_ERR;
          end else begin
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_CHECK;
      S_CHECK: begin
        if (dims_ok) begin
          state_d    = S_START;
        end else begin
          err_code_d = 2'd2;
          state_d    = S_ERR;
        end
      end
      S_START: begin
        state_d = S_WAIT;
`ifdef OP_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        // eng_done has priority over an expiring timeout in the same cycle
        if (bus.eng_done) begin
          res_m_d    = bus.eng_res_m;
          res_n_d    = bus.eng_res_n;
          res_flat_d = bus.eng_res_flat;
          state_d    = S_DONE;
        end
`ifdef OP_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          err_code_d = 2'd3;
          state_d    = S_ERR;
        end else begin
          wcnt_d     = wcnt_q + 1'b1;
        end
`endif
      end
      S_DONE: begin
        idx_d     = '0;
        started_d = 1'b0;
        state_d   = S_STORE;
      end
      S_STORE: begin
        // store_start presents element 0 in its own cycle, so the same advance
        // rule covers the first and later elements (and a zero-element result)
        if (started_q || bus.store_start) begin
          started_d = 1'b1;
          if ((idx_q + 6'd1) >= elem_cnt) begin
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_q + 6'd1;
          end
        end
      end
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched-context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      a_id_q     <= '0;
      b_id_q     <= '0;
      res_m_q    <= '0;
      res_n_q    <= '0;
      res_flat_q <= '0;
      err_code_q <= '0;
      idx_q      <= '0;
      started_q  <= 1'b0;
`ifdef OP_TIMEOUT_EN
      wcnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_id_q     <= a_id_d;
      b_id_q     <= b_id_d;
      res_m_q    <= res_m_d;
      res_n_q    <= res_n_d;
      res_flat_q <= res_flat_d;
      err_code_q <= err_code_d;
      idx_q      <= idx_d;
      started_q  <= started_d;
`ifdef OP_TIMEOUT_EN
      wcnt_q     <= wcnt_d;
`endif
    end
  end

  // Write-back element select; anything past m*n reads as zero
  always_comb begin
    result_data = '0;
    if ((state_q == S_STORE) && (idx_q < elem_cnt) && (32'(idx_q) < NELEM)) begin
      result_data = res_flat_q[32'(idx_q) * DATA_W +: DATA_W];
    end
  end

  assign bus.cmd_ready     = (state_q == S_IDLE);
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.load_operands = (state_q == S_LOAD);
  assign bus.eng_start     = (state_q == S_START);
  assign bus.op_done       = (state_q == S_DONE);
  assign bus.err_valid     = (state_q == S_ERR);
  assign bus.operand_a_id  = a_id_q;
  assign bus.operand_b_id  = b_id_q;
  assign bus.eng_op        = op_q;
  assign bus.result_m      = res_m_q;
  assign bus.result_n      = res_n_q;
  assign bus.err_code      = err_code_q;
  assign bus.result_data   = result_data;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed + randomized bench for matrix_op_sequencer with a storage/engine model.
module tb_matrix_op_sequencer;
  localparam int DW = 8;
  localparam int NE = 25;
`ifdef OP_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 255;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   dim_m[16];
  int   dim_n[16];

  matrix_op_sequencer_if #(.DATA_W(DW), .NELEM(NE)) bus ();

  matrix_op_sequencer #(.DATA_W(DW), .NELEM(NE), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shape rule as stated for each operation
  function automatic bit shapes_ok(input int op, input int am, input int an, input int bm, input int bn);
    if (op == 0 || op == 1) return (am == bm) && (an == bn);
    if (op == 2) return an == bm;
    return 1'b1;
  endfunction

  // Result shape the engine model produces
  function automatic void eng_shape(input int op, input int am, input int an, input int bn,
                                    output int rm, output int rn);
    case (op)
      2:       begin rm = am; rn = bn; end
      3:       begin rm = an; rn = am; end
      default: begin rm = am; rn = an; end
    endcase
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"},  bus.cmd_ready, 1);
    chk({tag, "_busy"},   bus.busy, 0);
    chk({tag, "_load"},   bus.load_operands, 0);
    chk({tag, "_start"},  bus.eng_start, 0);
    chk({tag, "_done"},   bus.op_done, 0);
    chk({tag, "_errv"},   bus.err_valid, 0);
    chk({tag, "_errc"},   bus.err_code, 0);
    chk({tag, "_aid"},    bus.operand_a_id, 0);
    chk({tag, "_bid"},    bus.operand_b_id, 0);
    chk({tag, "_engop"},  bus.eng_op, 0);
    chk({tag, "_rm"},     bus.result_m, 0);
    chk({tag, "_rn"},     bus.result_n, 0);
    chk({tag, "_rdata"},  bus.result_data, 0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    chk_reset_outputs(tag);
    rst = 1'b0;
    bus.eng_done = 1'b1;       // stray completion after abort must be ignored
    tick();
    bus.eng_done = 1'b0;
    chk({tag, "_stray_done"}, bus.op_done, 0);
    chk({tag, "_stray_errv"}, bus.err_valid, 0);
    tick();
    chk({tag, "_stray_done2"}, bus.op_done, 0);
    chk({tag, "_idle"}, bus.cmd_ready, 1);
  endtask

  // One command end to end. lat<0: never complete; fm/fn>=0 override engine result dims;
  // rst_at 1 = reset in WAIT, 2 = reset in STORE.
  task automatic do_cmd(input int op, input int aid, input int bid, input int lat,
                        input int sdly, input int fm, input int fn, input int rst_at);
    int am, an, bm, bn, rm, rn, cnt, nshow;
    bit illegal;
    logic [7:0] el[NE];
    logic [DW*NE-1:0] flat;
    illegal = (op > 4) || (aid > 9) || (op < 3 && bid > 9);
    bus.cmd_op    = 3'(op);
    bus.cmd_a_id  = 4'(aid);
    bus.cmd_b_id  = 4'(bid);
    bus.cmd_valid = 1'b1;
    chk("accept_ready", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    if (illegal) begin
      chk("illegal_errv", bus.err_valid, 1);
      chk("illegal_code", bus.err_code, 1);
      chk("illegal_noload", bus.load_operands, 0);
      tick();
      chk("illegal_errv_end", bus.err_valid, 0);
      chk("illegal_idle", bus.cmd_ready, 1);
      chk("illegal_code_hold", bus.err_code, 1);
      return;
    end
    chk("load_pulse", bus.load_operands, 1);
    chk("load_busy", bus.busy, 1);
    chk("load_notready", bus.cmd_ready, 0);
    chk("load_aid", bus.operand_a_id, aid);
    chk("load_bid", bus.operand_b_id, bid);
    chk("load_engop", bus.eng_op, op);
    chk("load_code_clr", bus.err_code, 0);
    am = dim_m[aid]; an = dim_n[aid]; bm = dim_m[bid]; bn = dim_n[bid];
    bus.a_m = 3'(am); bus.a_n = 3'(an); bus.b_m = 3'(bm); bus.b_n = 3'(bn);
    tick();
    chk("settle_load_off", bus.load_operands, 0);
    tick();
    chk("check_nostart", bus.eng_start, 0);
    tick();
    if (!shapes_ok(op, am, an, bm, bn)) begin
      chk("dim_errv", bus.err_valid, 1);
      chk("dim_code", bus.err_code, 2);
      chk("dim_nostart", bus.eng_start, 0);
      tick();
      chk("dim_idle", bus.cmd_ready, 1);
      chk("dim_errv_end", bus.err_valid, 0);
      return;
    end
    chk("start_pulse", bus.eng_start, 1);
    chk("start_noerr", bus.err_valid, 0);
`ifdef OP_TIMEOUT_EN
    if (lat < 0) begin
      for (int i = 0; i < TMO; i++) begin
        tick();
        chk("tmo_waiting", bus.err_valid, 0);
        chk("tmo_busy", bus.busy, 1);
      end
      tick();
      chk("tmo_errv", bus.err_valid, 1);
      chk("tmo_code", bus.err_code, 3);
      chk("tmo_nodone", bus.op_done, 0);
      bus.eng_done = 1'b1;
      tick();
      bus.eng_done = 1'b0;
      chk("tmo_idle", bus.cmd_ready, 1);
      tick();
      chk("tmo_late_done_ignored", bus.op_done, 0);
      chk("tmo_code_hold", bus.err_code, 3);
      return;
    end
`endif
    eng_shape(op, am, an, bn, rm, rn);
    if (fm >= 0) rm = fm;
    if (fn >= 0) rn = fn;
    cnt = rm * rn;
    for (int k = 0; k < NE; k++) begin
      el[k] = 8'($urandom_range(1, 255));
      flat[k*DW +: DW] = el[k];
    end
    for (int i = 0; i < lat; i++) begin
      tick();
      chk("wait_nodone", bus.op_done, 0);
      if (rst_at == 1) begin
        do_reset("rst_wait");
        return;
      end
      bus.cmd_valid = 1'b1;    // a command offered while busy must not be taken
      bus.cmd_op    = 3'd6;
    end
    bus.cmd_valid    = 1'b0;
    bus.eng_res_m    = 3'(rm);
    bus.eng_res_n    = 3'(rn);
    bus.eng_res_flat = flat;
    bus.eng_done     = 1'b1;
    tick();
    bus.eng_done     = 1'b0;
    bus.eng_res_flat = '0;
    chk("done_pulse", bus.op_done, 1);
    chk("done_rm", bus.result_m, rm);
    chk("done_rn", bus.result_n, rn);
    chk("done_code", bus.err_code, 0);
    tick();
    chk("store_done_off", bus.op_done, 0);
    for (int i = 0; i < sdly; i++) begin
      chk("store_hold_busy", bus.busy, 1);
      tick();
    end
    bus.store_start = 1'b1;
    nshow = (cnt == 0) ? 1 : cnt;
    for (int i = 0; i < nshow; i++) begin
      chk($sformatf("elem%0d", i), bus.result_data, (i < cnt) ? 32'(el[i]) : 32'd0);
      if (rst_at == 2 && i == 1) begin
        bus.store_start = 1'b0;
        do_reset("rst_store");
        return;
      end
      tick();
      bus.store_start = 1'b0;
    end
    chk("store_exit_ready", bus.cmd_ready, 1);
    chk("store_exit_busy", bus.busy, 0);
    chk("store_exit_rdata", bus.result_data, 0);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a_id = '0; bus.cmd_b_id = '0;
    bus.a_m = '0; bus.a_n = '0; bus.b_m = '0; bus.b_n = '0;
    bus.eng_done = 1'b0; bus.eng_res_m = '0; bus.eng_res_n = '0; bus.eng_res_flat = '0;
    bus.store_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      dim_m[i] = $urandom_range(1, 3);
      dim_n[i] = $urandom_range(1, 3);
    end
    dim_m[0] = 2; dim_n[0] = 3;
    dim_m[1] = 2; dim_n[1] = 3;
    dim_m[2] = 2; dim_n[2] = 2;
    dim_m[3] = 3; dim_n[3] = 5;

    rst = 1'b1;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    do_cmd(0, 0, 1, 3, 1, -1, -1, 0);   // add 2x3 + 2x3
    do_cmd(2, 0, 2, 2, 0, -1, -1, 0);   // mul 2x3 * 2x2 -> shape error
    do_cmd(6, 0, 1, 2, 0, -1, -1, 0);   // illegal opcode
    do_cmd(0, 12, 1, 2, 0, -1, -1, 0);  // illegal A id
    do_cmd(3, 3, 0, 4, 2, -1, -1, 0);   // transpose 3x5 -> 5x3
    do_cmd(4, 0, 0, 1, 0, 0, 3, 0);     // zero-row result
    do_cmd(1, 1, 0, 2, 0, -1, -1, 0);   // sub

    bus.eng_done = 1'b1;                // completion while idle
    tick();
    bus.eng_done = 1'b0;
    chk("idle_done_ignored", bus.op_done, 0);
    chk("idle_ready", bus.cmd_ready, 1);

    for (int r = 0; r < 24; r++) begin
      int op;
      op = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7));
      do_cmd(op, $urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(1, 6),
             $urandom_range(0, 2), -1, -1, 0);
    end

    do_cmd(0, 0, 1, 3, 0, -1, -1, 1);   // reset during WAIT
    do_cmd(0, 0, 1, 2, 1, -1, -1, 2);   // reset during STORE
    do_cmd(0, 0, 1, 2, 0, -1, -1, 0);   // clean operation after resets

`ifdef OP_TIMEOUT_EN
    do_cmd(0, 0, 1, -1, 0, -1, -1, 0);  // no completion -> timeout
    do_cmd(0, 0, 1, TMO, 0, -1, -1, 0); // completion on the expiry cycle wins
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
